// File: rtl/alu_acc.sv
// Accumulator ALU stage. It combines the reg_f operand with an internal
// accumulator. Single-cycle ops complete at the accept edge. MUL is a
// WIDTH-step shift-add sequence guarded by BUSY/DONE.
module alu_acc #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             START,
  input  logic [3:0]       OP,
  input  logic [WIDTH-1:0] OPND,
  output logic [WIDTH-1:0] RES,
  output logic             C,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LD  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_MUL = 4'd10;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     acc, acc_nxt;
  logic                 c_flag, c_nxt;
  logic                 z_flag, z_nxt;
  logic                 done, done_nxt;
  logic [WIDTH-1:0]     mcand, mcand_nxt;
  logic [WIDTH-1:0]     mplr, mplr_nxt;
  logic [2*WIDTH-1:0]   prod, prod_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [CW-1:0]        shamt;
  logic [2*WIDTH-1:0]   step_prod;
  logic [WIDTH:0]       sum;
  logic                 wr_acc;

  assign RES  = acc;
  assign C    = c_flag;
  assign Z    = z_flag;
  assign DONE = done;
  assign BUSY = (state == S_MUL);

  // State register; async reset aborts any MUL in flight with no DONE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= S_IDLE;
      acc    <= '0;
      c_flag <= 1'b0;
      z_flag <= 1'b1;
      done   <= 1'b0;
      mcand  <= '0;
      mplr   <= '0;
      prod   <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      c_flag <= c_nxt;
      z_flag <= z_nxt;
      done   <= done_nxt;
      mcand  <= mcand_nxt;
      mplr   <= mplr_nxt;
      prod   <= prod_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state: op decode in IDLE and one shift-add step per enabled MUL edge.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    c_nxt     = c_flag;
    z_nxt     = z_flag;
    done_nxt  = 1'b0;
    mcand_nxt = mcand;
    mplr_nxt  = mplr;
    prod_nxt  = prod;
    cnt_nxt   = cnt;
    wr_acc    = 1'b0;
    shamt     = CNT_INIT - cnt;
    sum       = {1'b0, acc} + {1'b0, OPND};
    if (mplr[0]) begin
      step_prod = prod + ({{WIDTH{1'b0}}, mcand} << shamt);
    end else begin
      step_prod = prod;
    end

    case (state)
      S_IDLE: begin
        if (EN && START) begin
          done_nxt = 1'b1;
          wr_acc   = 1'b1;
          case (OP)
            OP_LD:  acc_nxt = OPND;
            OP_ADD: begin
              acc_nxt = sum[WIDTH-1:0];
              c_nxt   = sum[WIDTH];
            end
            OP_SUB: begin
              acc_nxt = acc - OPND;
              c_nxt   = (acc < OPND);
            end
            OP_AND: acc_nxt = acc & OPND;
            OP_OR:  acc_nxt = acc | OPND;
            OP_XOR: acc_nxt = acc ^ OPND;
            OP_NOT: acc_nxt = ~acc;
            OP_SHL: begin
              c_nxt   = acc[WIDTH-1];
              acc_nxt = {acc[WIDTH-2:0], 1'b0};
            end
            OP_SHR: begin
              c_nxt   = acc[0];
              acc_nxt = {1'b0, acc[WIDTH-1:1]};
            end
            OP_MUL: begin
              // Operands are latched here; later OP/OPND changes are ignored.
              wr_acc    = 1'b0;
              done_nxt  = 1'b0;
              mcand_nxt = acc;
              mplr_nxt  = OPND;
              prod_nxt  = '0;
              cnt_nxt   = CNT_INIT;
              state_nxt = S_MUL;
            end
            default: wr_acc = 1'b0;  // NOP and unused codes
          endcase
        end else begin
          done_nxt = 1'b0;
        end
      end
      S_MUL: begin
        if (EN) begin
          prod_nxt = step_prod;
          mplr_nxt = mplr >> 1;
          cnt_nxt  = cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            acc_nxt   = step_prod[WIDTH-1:0];
            c_nxt     = |step_prod[2*WIDTH-1:WIDTH];
            wr_acc    = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_MUL;
          end
        end else begin
          state_nxt = S_MUL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (wr_acc) begin
      z_nxt = (acc_nxt == '0);
    end else begin
      z_nxt = z_nxt;
    end
  end

endmodule

// File: tb/tb_alu_acc.sv
// Randomized self-checking bench for alu_acc. A behavioural model mirrors the
// outputs. It computes MUL as a plain product and counts down enabled edges.
module tb_alu_acc;

  logic       CLK, RST, EN, START;
  logic [3:0] OP, OPND, RES;
  logic       C, Z, BUSY, DONE;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [3:0] m_acc;
  logic       m_c, m_z, m_busy, m_done;
  logic [7:0] m_prod;
  int         m_left;

  alu_acc #(.WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .OP(OP), .OPND(OPND),
    .RES(RES), .C(C), .Z(Z), .BUSY(BUSY), .DONE(DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_res"},  {28'd0, RES},  {28'd0, m_acc});
    check({tag, "_c"},    {31'd0, C},    {31'd0, m_c});
    check({tag, "_z"},    {31'd0, Z},    {31'd0, m_z});
    check({tag, "_busy"}, {31'd0, BUSY}, {31'd0, m_busy});
    check({tag, "_done"}, {31'd0, DONE}, {31'd0, m_done});
  endtask

  task automatic model_reset();
    m_acc = 4'd0; m_c = 1'b0; m_z = 1'b1; m_busy = 1'b0; m_done = 1'b0;
    m_prod = 8'd0; m_left = 0;
  endtask

  // Apply one clock edge with the given inputs, advance the model, then check.
  task automatic step(input logic en, input logic st, input logic [3:0] op,
                      input logic [3:0] opnd, input string tag);
    logic [4:0] s;
    EN = en; START = st; OP = op; OPND = opnd;
    @(posedge CLK);
    m_done = 1'b0;
    if (en) begin
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_acc  = m_prod[3:0];
          m_c    = (m_prod[7:4] != 4'd0);
          m_z    = (m_acc == 4'd0);
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (st) begin
        m_done = 1'b1;
        case (op)
          4'd1: m_acc = opnd;
          4'd2: begin s = m_acc + opnd; m_acc = s[3:0]; m_c = (s > 5'd15); end
          4'd3: begin m_c = (m_acc < opnd); m_acc = m_acc - opnd; end
          4'd4: m_acc = m_acc & opnd;
          4'd5: m_acc = m_acc | opnd;
          4'd6: m_acc = m_acc ^ opnd;
          4'd7: m_acc = ~m_acc;
          4'd8: begin m_c = m_acc[3]; m_acc = m_acc * 4'd2; end
          4'd9: begin m_c = m_acc[0]; m_acc = m_acc / 4'd2; end
          4'd10: begin
            m_prod = 8'(m_acc) * 8'(opnd);
            m_left = 4;
            m_busy = 1'b1;
            m_done = 1'b0;
          end
          default: ;
        endcase
        if (op >= 4'd1 && op <= 4'd9) m_z = (m_acc == 4'd0);
      end
    end
    #1;
    check_all(tag);
  endtask

  // Assert RST away from any clock edge and check outputs before the next edge.
  task automatic pulse_reset(input string tag);
    #2 RST = 1'b1;
    #1;
    model_reset();
    check({tag, "_res"},  {28'd0, RES},  32'd0);
    check({tag, "_c"},    {31'd0, C},    32'd0);
    check({tag, "_z"},    {31'd0, Z},    32'd1);
    check({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_done"}, {31'd0, DONE}, 32'd0);
    #1 RST = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [3:0] e;
    RST = 1'b1; EN = 1'b0; START = 1'b0; OP = 4'd0; OPND = 4'd0;
    model_reset();
    #12;
    check_all("init");
    @(negedge CLK) RST = 1'b0;
    @(posedge CLK); #1;

    // T1: reset mid-activity, including mid-MUL
    step(1'b1, 1'b1, 4'd1, 4'd7, "t1_ld");
    step(1'b1, 1'b1, 4'd10, 4'd3, "t1_mul");
    pulse_reset("t1_rst");

    // T2
    step(1'b1, 1'b1, 4'd1, 4'd9, "t2_ld");
    step(1'b1, 1'b1, 4'd2, 4'd9, "t2_add");
    check("t2_res_const", {28'd0, RES}, 32'd2);
    check("t2_c_const", {31'd0, C}, 32'd1);
    step(1'b1, 1'b0, 4'd0, 4'd0, "t2_idle");

    // T3
    step(1'b1, 1'b1, 4'd1, 4'd3, "t3_ld");
    step(1'b1, 1'b1, 4'd3, 4'd5, "t3_sub1");
    check("t3_res1_const", {28'd0, RES}, 32'd14);
    step(1'b1, 1'b1, 4'd3, 4'd14, "t3_sub2");
    check("t3_z_const", {31'd0, Z}, 32'd1);

    // T4: walking a one off the top, then off the bottom
    step(1'b1, 1'b1, 4'd1, 4'd1, "t4_ld");
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 4'd8, 4'd0, "t4_shl");
      e = 4'd1 << (k + 1);
      check("t4_shl_const", {28'd0, RES}, {28'd0, e});
    end
    check("t4_shl_c_const", {31'd0, C}, 32'd1);
    step(1'b1, 1'b1, 4'd1, 4'd1, "t4_ld2");
    step(1'b1, 1'b1, 4'd9, 4'd0, "t4_shr");
    check("t4_shr_c_const", {31'd0, C}, 32'd1);

    // T5: MUL 6*7 with START held during BUSY, then with an EN=0 gap
    for (int pass = 0; pass < 2; pass++) begin
      step(1'b1, 1'b1, 4'd1, 4'd6, "t5_ld");
      step(1'b1, 1'b1, 4'd10, 4'd7, "t5_acc");
      busy_cnt = BUSY ? 1 : 0;
      done_cnt = 0;
      for (int i = 0; i < 20; i++) begin
        step((pass == 1 && i >= 1 && i < 4) ? 1'b0 : 1'b1, 1'b1, 4'd1, 4'd15, "t5_run");
        if (BUSY) busy_cnt++;
        if (DONE) begin done_cnt++; break; end
      end
      check("t5_busy_cycles", busy_cnt, (pass == 1) ? 32'd7 : 32'd4);
      check("t5_done_pulses", done_cnt, 32'd1);
      check("t5_res_const", {28'd0, RES}, 32'd10);
      check("t5_c_const", {31'd0, C}, 32'd1);
    end

    // T6: reset during step 2 of 5*3
    step(1'b1, 1'b1, 4'd1, 4'd5, "t6_ld");
    step(1'b1, 1'b1, 4'd10, 4'd3, "t6_mul");
    step(1'b1, 1'b0, 4'd0, 4'd0, "t6_s1");
    pulse_reset("t6_rst");
    step(1'b1, 1'b1, 4'd1, 4'd9, "t6_ld2");
    check("t6_ld_const", {28'd0, RES}, 32'd9);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
